// File: rtl/mux_pkg.sv
// Shared constants for the 1:2 demux / 2:1 merge path.
package mux_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  // Channel indices, also the encoding carried on out_sel / demux s.
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way arbiter, round-robin or fixed priority (ch0 wins).
module rr_arb2
  import mux_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // One-hot grant; on contention round-robin favours the channel not served last.
  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (RR_EN && (last_grant == CH0)) gnt = 2'b10;
        else                              gnt = 2'b01;
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/mux2_rr_merge.sv
// Two-channel merge into a single registered stream tagged with its source index.
module mux2_rr_merge
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter bit          RR_EN  = 1'b1,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic       load;
  logic [1:0] gnt;
  logic       acc0, acc1;

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .req        ({in1_valid, in0_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Handshake: the single output slot can take a word when empty or draining.
  always_comb begin
    load      = ~out_valid_q | out_ready;
    in0_ready = load & gnt[0] & ~rst;
    in1_ready = load & gnt[1] & ~rst;
    acc0      = in0_ready;
    acc1      = in1_ready;
  end

  // Next-state for output slot, arbitration history and saturating counters.
  always_comb begin
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (load) begin
      out_valid_d = acc0 | acc1;
      if (acc0 | acc1) begin
        out_data_d   = acc1 ? in1_data : in0_data;
        out_sel_d    = acc1 ? CH1 : CH0;
        last_grant_d = acc1 ? CH1 : CH0;
      end
    end
    if (acc0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (acc1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  // State registers with synchronous reset; last_grant=CH1 lets ch0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_sel_q    <= CH0;
      out_valid_q  <= 1'b0;
      last_grant_q <= CH1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_mux2_rr_merge.sv
// Directed bench: round-robin instance table-driven; fixed-priority and
// 2-bit-counter instances checked with short hand-written sequences.
module tb_mux2_rr_merge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in0_data = '0, in1_data = '0;
  logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;

  // round-robin instance
  logic        m_r0, m_r1, m_ov, m_sel;
  logic [7:0]  m_od;
  logic [15:0] m_c0, m_c1;
  // fixed-priority instance
  logic        f_r0, f_r1, f_ov, f_sel;
  logic [7:0]  f_od;
  logic [15:0] f_c0, f_c1;
  // 2-bit counter instance
  logic        s_r0, s_r1, s_ov, s_sel;
  logic [7:0]  s_od;
  logic [1:0]  s_c0, s_c1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux2_rr_merge #(.DATA_W(8), .RR_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(m_r0),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(m_r1),
    .out_data(m_od), .out_sel(m_sel), .out_valid(m_ov), .out_ready(out_ready),
    .cnt0(m_c0), .cnt1(m_c1)
  );

  mux2_rr_merge #(.DATA_W(8), .RR_EN(1'b0), .CNT_W(16)) dut_fp (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(f_r0),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(f_r1),
    .out_data(f_od), .out_sel(f_sel), .out_valid(f_ov), .out_ready(out_ready),
    .cnt0(f_c0), .cnt1(f_c1)
  );

  mux2_rr_merge #(.DATA_W(8), .RR_EN(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(s_r0),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(s_r1),
    .out_data(s_od), .out_sel(s_sel), .out_valid(s_ov), .out_ready(out_ready),
    .cnt0(s_c0), .cnt1(s_c1)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [7:0]  d1;
    logic        ordy;
    logic        r0;
    logic        r1;
    logic        ov;
    logic        sel;
    logic [7:0]  od;
    logic [15:0] c0;
    logic [15:0] c1;
  } vec_t;

  localparam int NV = 18;
  vec_t tv[NV];

  function automatic vec_t mk(input logic rs, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1, input logic ordy,
                              input logic r0, input logic r1, input logic ov,
                              input logic sel, input logic [7:0] od,
                              input logic [15:0] c0, input logic [15:0] c1);
    vec_t v;
    v.rst = rs; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.sel = sel; v.od = od; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge, away from the sampling edge.
  task automatic drive(input logic rs, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic ordy);
    @(negedge clk);
    rst = rs; in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1;
    out_ready = ordy;
    #2;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             rst v0 d0     v1 d1     ordy | r0 r1 ov sel od     c0 c1
    tv[0]  = mk(1, 1, 8'h11, 1, 8'h22, 1,   0, 0, 0, 0, 8'h00, 0, 0);
    tv[1]  = mk(1, 1, 8'h11, 1, 8'h22, 1,   0, 0, 0, 0, 8'h00, 0, 0);
    tv[2]  = mk(0, 1, 8'h11, 1, 8'h22, 1,   1, 0, 1, 0, 8'h11, 1, 0);
    tv[3]  = mk(0, 1, 8'h11, 1, 8'h22, 1,   0, 1, 1, 1, 8'h22, 1, 1);
    tv[4]  = mk(0, 1, 8'h11, 1, 8'h22, 1,   1, 0, 1, 0, 8'h11, 2, 1);
    tv[5]  = mk(0, 1, 8'h11, 1, 8'h22, 1,   0, 1, 1, 1, 8'h22, 2, 2);
    tv[6]  = mk(0, 1, 8'h11, 1, 8'h22, 1,   1, 0, 1, 0, 8'h11, 3, 2);
    tv[7]  = mk(0, 1, 8'h11, 1, 8'h22, 1,   0, 1, 1, 1, 8'h22, 3, 3);
    tv[8]  = mk(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 1, 8'h22, 3, 3);
    tv[9]  = mk(0, 1, 8'hA5, 0, 8'h00, 1,   1, 0, 1, 0, 8'hA5, 4, 3);
    tv[10] = mk(0, 1, 8'h33, 1, 8'h44, 0,   0, 0, 1, 0, 8'hA5, 4, 3);
    tv[11] = mk(0, 1, 8'h33, 1, 8'h44, 0,   0, 0, 1, 0, 8'hA5, 4, 3);
    tv[12] = mk(0, 1, 8'h33, 1, 8'h44, 0,   0, 0, 1, 0, 8'hA5, 4, 3);
    tv[13] = mk(0, 1, 8'h33, 1, 8'h44, 1,   0, 1, 1, 1, 8'h44, 4, 4);
    tv[14] = mk(0, 1, 8'h33, 1, 8'h44, 1,   1, 0, 1, 0, 8'h33, 5, 4);
    tv[15] = mk(0, 0, 8'h00, 1, 8'h44, 0,   0, 0, 1, 0, 8'h33, 5, 4);
    tv[16] = mk(1, 1, 8'h11, 1, 8'h22, 0,   0, 0, 0, 0, 8'h00, 0, 0);
    tv[17] = mk(0, 1, 8'h11, 1, 8'h22, 1,   1, 0, 1, 0, 8'h11, 1, 0);

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].rst, tv[i].v0, tv[i].d0, tv[i].v1, tv[i].d1, tv[i].ordy);
      chk($sformatf("v%0d in0_ready", i), {31'd0, m_r0}, {31'd0, tv[i].r0});
      chk($sformatf("v%0d in1_ready", i), {31'd0, m_r1}, {31'd0, tv[i].r1});
      edge_wait();
      chk($sformatf("v%0d out_valid", i), {31'd0, m_ov},  {31'd0, tv[i].ov});
      chk($sformatf("v%0d out_sel", i),   {31'd0, m_sel}, {31'd0, tv[i].sel});
      chk($sformatf("v%0d out_data", i),  {24'd0, m_od},  {24'd0, tv[i].od});
      chk($sformatf("v%0d cnt0", i),      {16'd0, m_c0},  {16'd0, tv[i].c0});
      chk($sformatf("v%0d cnt1", i),      {16'd0, m_c1},  {16'd0, tv[i].c1});
    end

    // Fixed priority: ch0 always wins contention, ch1 never served.
    drive(1, 1, 8'h11, 1, 8'h22, 1);
    edge_wait();
    chk("fp reset out_valid", {31'd0, f_ov}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      drive(0, 1, 8'h11, 1, 8'h22, 1);
      chk($sformatf("fp c%0d in1_ready", k), {31'd0, f_r1}, 32'd0);
      chk($sformatf("fp c%0d in0_ready", k), {31'd0, f_r0}, 32'd1);
      edge_wait();
      chk($sformatf("fp c%0d out_sel", k),  {31'd0, f_sel}, 32'd0);
      chk($sformatf("fp c%0d out_data", k), {24'd0, f_od},  32'h11);
    end
    chk("fp cnt0", {16'd0, f_c0}, 32'd6);
    chk("fp cnt1", {16'd0, f_c1}, 32'd0);

    // 2-bit counters saturate at 3; reset mid-run clears slot and counters.
    drive(1, 0, 8'h00, 0, 8'h00, 1);
    edge_wait();
    chk("sat reset cnt1", {30'd0, s_c1}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 8'h00, 1, 8'h5A, 1);
      chk($sformatf("sat a%0d in1_ready", k), {31'd0, s_r1}, 32'd1);
      edge_wait();
      chk($sformatf("sat a%0d cnt1", k), {30'd0, s_c1}, (k > 3) ? 32'd3 : k);
    end
    chk("sat out_valid", {31'd0, s_ov}, 32'd1);
    chk("sat out_sel", {31'd0, s_sel}, 32'd1);
    drive(1, 1, 8'h11, 1, 8'h22, 0);
    chk("sat rst in0_ready", {31'd0, s_r0}, 32'd0);
    chk("sat rst in1_ready", {31'd0, s_r1}, 32'd0);
    edge_wait();
    chk("sat rst out_valid", {31'd0, s_ov}, 32'd0);
    chk("sat rst cnt1", {30'd0, s_c1}, 32'd0);
    chk("sat rst cnt0", {30'd0, s_c0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
